// File: rtl/g_alu_32.sv
// 32-bit ALU: ADD/SUB on a shared full-adder carry chain, logic ops and shifts,
// with the result and carry flag registered.

module g_alu_32_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module g_alu_32_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_chain
    g_alu_32_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[W];
endmodule

module g_alu_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        CI,
  input  logic [2:0]  A,
  output logic [31:0] FinalOut,
  output logic        CO
);
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_e;

  op_e         op;
  logic        is_sub;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [31:0] result;
  logic        carry;

  assign op = op_e'(A);

  // SUB reuses the adder as In1 + ~In2 + ~CI, so CO reads as "no borrow".
  assign is_sub  = (op == OP_SUB);
  assign add_b   = is_sub ? ~In2 : In2;
  assign add_cin = is_sub ? ~CI  : CI;

  g_alu_32_adder #(.W(32)) u_adder (
    .a    (In1),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD,
      OP_SUB: begin
        result = add_sum;
        carry  = add_cout;
      end
      OP_AND:  result = In1 & In2;
      OP_OR:   result = In1 | In2;
      OP_XOR:  result = In1 ^ In2;
      OP_NOR:  result = ~(In1 | In2);
      OP_SLL:  result = In1 << In2[4:0];
      OP_SRL:  result = In1 >> In2[4:0];
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FinalOut <= '0;
      CO       <= 1'b0;
    end else begin
      FinalOut <= result;
      CO       <= carry;
    end
  end
endmodule

// File: tb/tb_g_alu_32.sv
// Scoreboard bench for g_alu_32: the driver queues expected results, a monitor
// compares them one cycle after each operation is applied.

module tb_g_alu_32;
  logic        clk;
  logic        rst_n;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        CI;
  logic [2:0]  A;
  logic [31:0] FinalOut;
  logic        CO;

  typedef struct {
    logic [31:0] res;
    logic        co;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  g_alu_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .In1      (In1),
    .In2      (In2),
    .CI       (CI),
    .A        (A),
    .FinalOut (FinalOut),
    .CO       (CO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act_r, input logic act_c,
                       input logic [31:0] exp_r, input logic exp_c);
    checks++;
    if (act_r !== exp_r || act_c !== exp_c) begin
      failures++;
      $display("FAIL %s: got FinalOut=%h CO=%b, expected FinalOut=%h CO=%b",
               nm, act_r, act_c, exp_r, exp_c);
    end
  endtask

  // Independent reference: plain 33-bit arithmetic.
  function automatic logic [32:0] model(input logic [31:0] a1, input logic [31:0] a2,
                                        input logic c, input logic [2:0] op);
    logic [32:0] r;
    case (op)
      3'd0:    r = {1'b0, a1} + {1'b0, a2} + {32'd0, c};
      3'd1:    r = {1'b0, a1} + {1'b0, ~a2} + {32'd0, ~c};
      3'd2:    r = {1'b0, a1 & a2};
      3'd3:    r = {1'b0, a1 | a2};
      3'd4:    r = {1'b0, a1 ^ a2};
      3'd5:    r = {1'b0, ~(a1 | a2)};
      3'd6:    r = {1'b0, a1 << a2[4:0]};
      default: r = {1'b0, a1 >> a2[4:0]};
    endcase
    return r;
  endfunction

  task automatic drive(input logic [31:0] i1, input logic [31:0] i2, input logic c,
                       input logic [2:0] op, input logic [31:0] er, input logic ec,
                       input string nm);
    exp_t e;
    @(negedge clk);
    In1 = i1;
    In2 = i2;
    CI  = c;
    A   = op;
    e.res  = er;
    e.co   = ec;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs update every edge, so each queued entry matches the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, FinalOut, CO, e.res, e.co);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no completion, expected end of test");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] m;
    logic [31:0] r1, r2;
    logic        rc;
    int          wait_cycles;
    checks   = 0;
    failures = 0;

    // Reset with arbitrary inputs, checked before any clock edge.
    rst_n = 1'b0;
    In1   = 32'hDEADBEEF;
    In2   = 32'h12345678;
    CI    = 1'b1;
    A     = 3'b000;
    #2;
    check("reset_no_clock", FinalOut, CO, 32'h0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    In1 = 32'd1; In2 = 32'd1; CI = 1'b0; A = 3'b000;
    begin
      exp_t e;
      e.res = 32'd2; e.co = 1'b0; e.name = "first_after_reset";
      exp_q.push_back(e);
    end

    drive(32'd4325, 32'd464, 1'b0, 3'b000, 32'd4789,       1'b0, "sweep_add");
    drive(32'd4325, 32'd464, 1'b0, 3'b001, 32'd3861,       1'b1, "sweep_sub");
    drive(32'd4325, 32'd464, 1'b0, 3'b010, 32'd192,        1'b0, "sweep_and");
    drive(32'd4325, 32'd464, 1'b0, 3'b011, 32'd4597,       1'b0, "sweep_or");
    drive(32'd4325, 32'd464, 1'b0, 3'b100, 32'd4405,       1'b0, "sweep_xor");
    drive(32'd4325, 32'd464, 1'b0, 3'b101, 32'hFFFFEE0A,   1'b0, "sweep_nor");
    drive(32'd4325, 32'd464, 1'b0, 3'b110, 32'h10E50000,   1'b0, "sweep_sll");
    drive(32'd4325, 32'd464, 1'b0, 3'b111, 32'd0,          1'b0, "sweep_srl");

    drive(32'hFFFFFFFF, 32'd0, 1'b1, 3'b000, 32'd0,        1'b1, "add_wrap");
    drive(32'd0,        32'd1, 1'b0, 3'b001, 32'hFFFFFFFF, 1'b0, "sub_borrow");
    drive(32'd5,        32'd3, 1'b1, 3'b001, 32'd1,        1'b1, "sub_borrow_in");
    drive(32'h80000001, 32'h20, 1'b0, 3'b110, 32'h80000001, 1'b0, "sll_amount0");
    drive(32'h80000001, 32'd31, 1'b0, 3'b111, 32'd1,        1'b0, "srl_31");
    drive(32'h00000001, 32'hFFFFFFE4, 1'b0, 3'b110, 32'h00000010, 1'b0, "sll_high_ignored");
    drive(32'h7FFFFFFF, 32'd1, 1'b0, 3'b000, 32'h80000000, 1'b0, "add_no_carry_msb");

    // Let the queue drain before the mid-operation reset.
    @(negedge clk);
    @(negedge clk);

    // Load a nonzero result, then reset asynchronously mid-cycle.
    In1 = 32'd100; In2 = 32'd23; CI = 1'b0; A = 3'b000;
    @(posedge clk);
    #2;
    check("preload_before_reset", FinalOut, CO, 32'd123, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", FinalOut, CO, 32'h0, 1'b0);
    In1 = 32'hFFFFFFFF; In2 = 32'd1; CI = 1'b0; A = 3'b000;
    @(posedge clk);
    #1;
    check("reset_held_over_edge", FinalOut, CO, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    In1 = 32'd7; In2 = 32'd9; CI = 1'b1; A = 3'b000;
    begin
      exp_t e;
      e.res = 32'd17; e.co = 1'b0; e.name = "first_after_mid_reset";
      exp_q.push_back(e);
    end

    // Opcode toggles every cycle against the delayed reference model.
    for (int i = 0; i < 48; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      rc = 1'($urandom_range(0, 1));
      m  = model(r1, r2, rc, 3'(i % 8));
      drive(r1, r2, rc, 3'(i % 8), m[31:0], m[32], $sformatf("toggle_%0d", i));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/g_alu_32.md
G_ALU_32 -- requirements
Module: g_alu_32

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for the output registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 In1  input  32  operand 1, unsigned.
REQ-005 In2  input  32  operand 2; bits [4:0] are the shift amount for shift ops.
REQ-006 CI  input  1  carry-in for ADD; borrow-in for SUB.
REQ-007 A  input  3  operation select.
REQ-008 FinalOut  output  32  registered result.
REQ-009 CO  output  1  registered carry/no-borrow flag.

Function
REQ-010 The datapath SHALL be combinational from In1, In2, CI and A, followed by one register stage on FinalOut and CO.
REQ-011 Latency SHALL be one cycle: inputs sampled at rising edge N appear on FinalOut/CO after edge N.
REQ-012 The registers SHALL load every cycle; there is no enable and no handshake.
REQ-013 A=000 ADD: FinalOut = (In1 + In2 + CI) mod 2^32; CO = bit 32 of the sum.
REQ-014 A=001 SUB: FinalOut = (In1 + ~In2 + ~CI) mod 2^32, i.e. In1 - In2 - CI; CO = bit 32 of that sum (1 = no borrow).
REQ-015 A=010 AND: FinalOut = In1 & In2; CO = 0.
REQ-016 A=011 OR: FinalOut = In1 | In2; CO = 0.
REQ-017 A=100 XOR: FinalOut = In1 ^ In2; CO = 0.
REQ-018 A=101 NOR: FinalOut = ~(In1 | In2); CO = 0.
REQ-019 A=110 SLL: FinalOut = In1 << In2[4:0], zero-filled; In2[31:5] ignored; CO = 0.
REQ-020 A=111 SRL: FinalOut = In1 >> In2[4:0], zero-filled; In2[31:5] ignored; CO = 0.
REQ-021 ADD and SUB SHALL share one 32-bit adder built as a carry chain of 1-bit full adders, with In2 and CI inverted for SUB.
REQ-022 Boundary behaviour:
- Arithmetic wraps modulo 2^32; overflow is reported only through CO.
- A shift amount of 0 SHALL pass In1 unchanged.
- A change of A or the operands takes effect on the next rising edge, with no hazard on the registered outputs.

Reset
REQ-023 While rst_n = 0, FinalOut SHALL be 32'h0 and CO SHALL be 0, immediately and independent of clk.
REQ-024 On rst_n deassertion, the first rising edge SHALL load the current operation result; reset asserted mid-operation discards any pending result.

Verification
REQ-025 Reset: rst_n=0 with arbitrary inputs -> FinalOut=0, CO=0 without a clock edge; release, then In1=1, In2=1, A=000 -> 2 after the next edge.
REQ-026 Opcode sweep: In1=4325, In2=464, CI=0, A stepped 000..111 -> expected results:
- ADD 4789, CO=1'b0.
- SUB 3861, CO=1.
- AND 192.
- OR 4597.
- XOR 4405.
- NOR 32'hFFFFEE0A.
- SLL 32'h10E50000.
- SRL 0.
- Each result is visible one cycle after A is applied.
REQ-027 ADD wrap: In1=32'hFFFFFFFF, In2=0, CI=1, A=000 -> FinalOut=0, CO=1.
REQ-028 SUB borrow: In1=0, In2=1, CI=0, A=001 -> FinalOut=32'hFFFFFFFF, CO=0; In1=5, In2=3, CI=1 -> FinalOut=1, CO=1.
REQ-029 Shift boundaries: In1=32'h80000001, A=110 with In2=32'h20 (amount 0) -> 32'h80000001; A=111 with In2=31 -> 1.
REQ-030 Latency: toggle A every cycle and compare against a reference model delayed by one cycle; any mismatch fails.
